// File: rtl/gfa_komut_isleyici_pkg.sv
// Shared constants for the command executor: opcodes, field positions, FSM states.
// Optional counters in the top are enabled with GFA_KOMUT_SAYAC_EN.
package gfa_komut_isleyici_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_YAZ   = 4'd1;
    localparam logic [3:0] OP_OKU   = 4'd2;
    localparam logic [3:0] OP_TOPLA = 4'd3;
    localparam logic [3:0] OP_DURUM = 4'd4;

    localparam int OP_LSB  = 28;
    localparam int IDX_LSB = 24;
    localparam int IMM_W   = 24;

    localparam logic [27:0] GECERSIZ_ONEK = 28'hDEAD000;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        ISLE  = 2'd1,
        BEKLE = 2'd2
    } durum_t;

endpackage

// File: rtl/gfa_komut_isleyici_yanit_fifo.sv
// Generic synchronous FIFO; head is visible combinationally, 1-cycle write-to-read.
// Writes when full and reads when empty are ignored; full means no push-through.
module gfa_yanit_fifo #(
    parameter int W        = 32,
    parameter int DERINLIK = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        push,
    input  logic [W-1:0]                push_dat,
    input  logic                        pop,
    output logic [W-1:0]                bas,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DERINLIK):0]   count
);
    localparam int AW = $clog2(DERINLIK);

    logic [W-1:0]  mem [DERINLIK];
    logic [AW-1:0] wptr, rptr;
    logic          wr, rd;

    assign full  = (count == (AW+1)'(DERINLIK));
    assign empty = (count == '0);
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign bas   = mem[rptr];

    always_ff @(posedge ACLK) begin
        if (wr) mem[wptr] <= push_dat;
    end

    // Depth is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gfa_komut_isleyici.sv
// Command executor: latches a command, executes it next cycle against the register bank,
// pushes read/status/illegal results to the response FIFO; stalls in BEKLE while it is full.
// Optional GFA_KOMUT_SAYAC_EN adds executed/illegal command counters to the status word.
module gfa_komut_isleyici
    import gfa_komut_isleyici_pkg::*;
#(
    parameter int VERI_BIT      = 32,
    parameter int REG_SAYISI    = 16,
    parameter int FIFO_DERINLIK = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [VERI_BIT-1:0] komut,
    input  logic                komut_gecerli,
    output logic                komut_hazir,
    output logic [VERI_BIT-1:0] veri,
    output logic                veri_gecerli,
    input  logic                veri_hazir,
    output logic                mesgul
);
    localparam int IDX_W = $clog2(REG_SAYISI);
    localparam int SAY_W = $clog2(FIFO_DERINLIK) + 1;

    durum_t              durum;
    logic [VERI_BIT-1:0] komut_r, bekleyen;
    logic [VERI_BIT-1:0] reg_bank [REG_SAYISI];
    logic [3:0]          op;
    logic [IDX_W-1:0]    idx;
    logic [IMM_W-1:0]    imm;
    logic                yanit_gerek;
    logic [VERI_BIT-1:0] yanit, durum_kelimesi, push_dat, fifo_bas;
    logic                push_en, pop_en, tamam;
    logic                fifo_dolu, fifo_bos;
    logic [SAY_W-1:0]    fifo_sayi;

    assign op  = komut_r[OP_LSB +: 4];
    assign idx = komut_r[IDX_LSB +: IDX_W];
    assign imm = komut_r[IMM_W-1:0];

    always_comb begin
        yanit_gerek = 1'b0;
        yanit       = '0;
        case (op)
            OP_NOP, OP_YAZ, OP_TOPLA: ;
            OP_OKU: begin
                yanit_gerek = 1'b1;
                yanit       = reg_bank[idx];
            end
            OP_DURUM: begin
                yanit_gerek = 1'b1;
                yanit       = durum_kelimesi;
            end
            default: begin
                yanit_gerek = 1'b1;
                yanit       = {GECERSIZ_ONEK, op};
            end
        endcase
    end

    assign push_en  = ((durum == ISLE) && yanit_gerek && !fifo_dolu) ||
                      ((durum == BEKLE) && !fifo_dolu);
    assign push_dat = (durum == BEKLE) ? bekleyen : yanit;
    assign pop_en   = veri_hazir && !fifo_bos;
    assign tamam    = ((durum == ISLE) && !(yanit_gerek && fifo_dolu)) ||
                      ((durum == BEKLE) && !fifo_dolu);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            durum       <= BOS;
            komut_hazir <= 1'b1;
            mesgul      <= 1'b0;
            komut_r     <= '0;
            bekleyen    <= '0;
            for (int i = 0; i < REG_SAYISI; i++) reg_bank[i] <= '0;
        end else begin
            case (durum)
                BOS: if (komut_gecerli) begin
                    komut_r     <= komut;
                    durum       <= ISLE;
                    komut_hazir <= 1'b0;
                    mesgul      <= 1'b1;
                end
                ISLE: begin
                    if (op == OP_YAZ)
                        reg_bank[idx] <= {{(VERI_BIT-IMM_W){1'b0}}, imm};
                    else if (op == OP_TOPLA)
                        reg_bank[idx] <= reg_bank[idx] + {{(VERI_BIT-IMM_W){imm[IMM_W-1]}}, imm};
                    if (yanit_gerek && fifo_dolu) begin
                        bekleyen <= yanit;
                        durum    <= BEKLE;
                    end else begin
                        durum       <= BOS;
                        komut_hazir <= 1'b1;
                        mesgul      <= 1'b0;
                    end
                end
                BEKLE: if (!fifo_dolu) begin
                    durum       <= BOS;
                    komut_hazir <= 1'b1;
                    mesgul      <= 1'b0;
                end
                default: begin
                    durum       <= BOS;
                    komut_hazir <= 1'b1;
                    mesgul      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GFA_KOMUT_SAYAC_EN
    logic [15:0] yurutulen_say;
    logic [7:0]  gecersiz_say;

    // Counted on completion, so a DURUM reports the count before itself.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            yurutulen_say <= '0;
            gecersiz_say  <= '0;
        end else if (tamam && (op != OP_NOP)) begin
            yurutulen_say <= yurutulen_say + 1'b1;
            if ((op > OP_DURUM) && (gecersiz_say != 8'hFF))
                gecersiz_say <= gecersiz_say + 1'b1;
        end
    end

    assign durum_kelimesi = {yurutulen_say, gecersiz_say, 8'(fifo_sayi)};
`else
    assign durum_kelimesi = {{(VERI_BIT-8){1'b0}}, 8'(fifo_sayi)};
`endif

    gfa_yanit_fifo #(
        .W        (VERI_BIT),
        .DERINLIK (FIFO_DERINLIK)
    ) u_yanit_fifo (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .push     (push_en),
        .push_dat (push_dat),
        .pop      (pop_en),
        .bas      (fifo_bas),
        .full     (fifo_dolu),
        .empty    (fifo_bos),
        .count    (fifo_sayi)
    );

    assign veri_gecerli = !fifo_bos;
    assign veri         = fifo_bos ? '0 : fifo_bas;

endmodule

// File: tb/tb_gfa_komut_isleyici.sv
// Bench for gfa_komut_isleyici: directed scenarios plus random commands against a
// queue-based reference model of the register bank and response stream.
module tb_gfa_komut_isleyici;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] komut;
    logic        komut_gecerli;
    logic        komut_hazir;
    logic [31:0] veri;
    logic        veri_gecerli;
    logic        veri_hazir;
    logic        mesgul;

    gfa_komut_isleyici #(
        .VERI_BIT      (32),
        .REG_SAYISI    (16),
        .FIFO_DERINLIK (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .komut         (komut),
        .komut_gecerli (komut_gecerli),
        .komut_hazir   (komut_hazir),
        .veri          (veri),
        .veri_gecerli  (veri_gecerli),
        .veri_hazir    (veri_hazir),
        .mesgul        (mesgul)
    );

    always #5 ACLK = ~ACLK;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] m_reg [16];
    logic [31:0] q [$];
    int          m_exec = 0;
    int          m_ill  = 0;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
        q.delete();
        m_exec = 0;
        m_ill  = 0;
    endtask

    // Reference semantics of one command; the queue is the expected response stream.
    task automatic model(input logic [31:0] c);
        int          op;
        int          ix;
        logic [31:0] se;
        logic [31:0] st;
        op = int'(c[31:28]);
        ix = int'(c[27:24]);
        se = {{8{c[23]}}, c[23:0]};
        case (op)
            0: ;
            1: m_reg[ix] = {8'h00, c[23:0]};
            2: q.push_back(m_reg[ix]);
            3: m_reg[ix] = m_reg[ix] + se;
            4: begin
`ifdef GFA_KOMUT_SAYAC_EN
                st = {16'(m_exec), 8'(m_ill), 8'(q.size())};
`else
                st = {24'h0, 8'(q.size())};
`endif
                q.push_back(st);
            end
            default: begin
                q.push_back({28'hDEAD000, c[31:28]});
                if (m_ill < 255) m_ill = m_ill + 1;
            end
        endcase
        if (op != 0) m_exec = m_exec + 1;
    endtask

    // Waits (bounded) for ready, presents the command for one cycle, then lets ISLE run.
    task automatic send(input logic [31:0] c, input bit gecikme);
        int n = 0;
        while (!komut_hazir && n < 20) begin
            tick();
            n++;
        end
        if (!komut_hazir) begin
            chk("komut_hazir_timeout", {31'b0, komut_hazir}, 32'd1);
            return;
        end
        komut         = c;
        komut_gecerli = 1'b1;
        tick();
        komut_gecerli = 1'b0;
        komut         = $urandom;
        model(c);
        if (gecikme) chk("gecikme_vld_N", {31'b0, veri_gecerli}, 32'd0);
        tick();
        if (gecikme) chk("gecikme_vld_N1", {31'b0, veri_gecerli}, 32'd1);
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, "_vld"}, {31'b0, veri_gecerli}, 32'd1);
        chk(tag, veri, q[0]);
        veri_hazir = 1'b1;
        tick();
        veri_hazir = 1'b0;
        q.delete(0);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) pop_chk(tag);
        chk({tag, "_bos"}, {31'b0, veri_gecerli}, 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        logic [3:0]  rop;
        ARESET        = 1'b1;
        komut         = 32'h0;
        komut_gecerli = 1'b0;
        veri_hazir    = 1'b0;
        model_reset();
        tick();
        tick();
        ARESET = 1'b0;

        chk("rst_komut_hazir", {31'b0, komut_hazir}, 32'd1);
        chk("rst_veri_gecerli", {31'b0, veri_gecerli}, 32'd0);
        chk("rst_veri", veri, 32'h0);
        chk("rst_mesgul", {31'b0, mesgul}, 32'd0);

        // YAZ then OKU, with the one-cycle response latency
        send(32'h1300_00AB, 1'b0);
        send(32'h2300_0000, 1'b1);
        chk("oku_ab", veri, 32'h0000_00AB);
        drain("oku");

        // TOPLA sign-extends its immediate, both directions
        send(32'h15FF_FFFF, 1'b0);
        send(32'h3500_0001, 1'b0);
        send(32'h2500_0000, 1'b0);
        chk("topla_arti", veri, 32'h0100_0000);
        drain("topla");
        send(32'h35FF_FFFF, 1'b0);
        send(32'h2500_0000, 1'b0);
        chk("topla_eksi", veri, 32'h00FF_FFFF);
        drain("topla2");

        // All-ones command is illegal and must not touch reg15
        send(32'hFFFF_FFFF, 1'b0);
        chk("gecersiz", veri, 32'hDEAD_000F);
        send(32'h2F00_0000, 1'b0);
        drain("gecersiz");

        // NOP produces nothing
        send(32'h0000_1234, 1'b0);
        chk("nop_yanit_yok", {31'b0, veri_gecerli}, 32'd0);

        // Five OKU into a depth-4 FIFO with no drain: fifth waits in BEKLE
        for (int i = 0; i < 5; i++) send({4'h2, 4'(i + 3), 24'h0}, 1'b0);
        chk("bekle_komut_hazir", {31'b0, komut_hazir}, 32'd0);
        chk("bekle_mesgul", {31'b0, mesgul}, 32'd1);
        chk("bekle_bas", veri, q[0]);
        veri_hazir = 1'b1;
        tick();
        veri_hazir = 1'b0;
        q.delete(0);
        chk("bekle_pop_sonrasi_hazir", {31'b0, komut_hazir}, 32'd0);
        tick();
        chk("bekle_cikis_hazir", {31'b0, komut_hazir}, 32'd1);
        chk("bekle_cikis_mesgul", {31'b0, mesgul}, 32'd0);
        drain("bekle");

        // DURUM sees two queued entries
        send(32'h2500_0000, 1'b0);
        send(32'h2300_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        pop_chk("durum_q0");
        pop_chk("durum_q1");
        chk("durum_sayi", {24'h0, veri[7:0]}, 32'h0000_0002);
        drain("durum");

        // Reset while stalled in BEKLE with a full FIFO
        for (int i = 0; i < 5; i++) send(32'h2500_0000, 1'b0);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        model_reset();
        chk("arst_veri_gecerli", {31'b0, veri_gecerli}, 32'd0);
        chk("arst_komut_hazir", {31'b0, komut_hazir}, 32'd1);
        send(32'h2500_0000, 1'b0);
        chk("arst_reg5", veri, 32'h0);
        send(32'h2300_0000, 1'b0);
        drain("arst");

        // Random commands, a few buffered at a time
        for (int k = 0; k < 80; k++) begin
            rop = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) rop = 4'hF;
            c = {rop, 4'($urandom), 24'($urandom)};
            send(c, 1'b0);
            if (q.size() >= 3 || $urandom_range(0, 1) == 1) drain("rnd");
        end
        drain("rnd_son");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
